serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 144 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start-bit-triggered serial receiver. It samples `in`
// only on `shift` strobes, shifts DATA_W bits in MSB first, checks the
// stop bit, and holds the word behind a valid/ready handshake.
// `frame_err` and `overrun` are single-cycle pulses.
// Optional feature: define SERIAL_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module serial_frame_rx #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in,
  input  logic              shift,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              consume;
  logic              frame_good;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_ok_q, par_ok_d;
`endif

  assign consume = vld_q & out_ready;

  // Next-state: FSM, counter and sreg move only on strobes; the handshake
  // and the error pulses are evaluated every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    out_d      = out_q;
    vld_d      = vld_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    frame_good = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_ok_d   = par_ok_q;
`endif
    if (consume) begin
      vld_d = 1'b0;
    end
    if (shift) begin
      case (state_q)
        S_IDLE: begin
          if (!in) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          sreg_d = {sreg_q[DATA_W-2:0], in};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_ok_d = ~(^{sreg_q, in});
          state_d  = S_STOP;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
          frame_good = in & par_ok_q;
`else
          frame_good = in;
`endif
          // A bad frame never reports an overrun, even with the slot full.
          if (!frame_good) begin
            ferr_d = 1'b1;
          end else if (!vld_q || out_ready) begin
            out_d = sreg_q;
            vld_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_ok_q <= par_ok_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=4). Vector table plus a few
// hand-written multi-cycle sequences; expected values are hand-computed.
module tb_serial_frame_rx;

  logic       clock = 1'b0;
  logic       clear, in, shift, out_ready;
  logic [3:0] out;
  logic       out_valid, busy, frame_err, overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  serial_frame_rx #(.DATA_W(4)) dut (
    .clock     (clock),
    .clear     (clear),
    .in        (in),
    .shift     (shift),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr;
    logic       din;
    logic       sh;
    logic       rdy;
    logic [3:0] eout;
    logic       evld;
    logic       ebusy;
    logic       eferr;
    logic       eovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic c, input logic d, input logic s, input logic r,
                            input logic [3:0] eo, input logic ev, input logic eb,
                            input logic ef, input logic eov);
    vec_t t;
    t.clr = c; t.din = d; t.sh = s; t.rdy = r;
    t.eout = eo; t.evld = ev; t.ebusy = eb; t.eferr = ef; t.eovr = eov;
    tbl.push_back(t);
  endfunction

  // Drive one cycle of inputs, then compare the outputs seen after the edge.
  task automatic step(input logic c, input logic d, input logic s, input logic r,
                      input logic [3:0] eo, input logic ev, input logic eb,
                      input logic ef, input logic eov, input string name);
    logic [7:0] got, exp;
    clear = c; in = d; shift = s; out_ready = r;
    @(posedge clock);
    #1;
    got = {out, out_valid, busy, frame_err, overrun};
    exp = {eo, ev, eb, ef, eov};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%b vld=%b busy=%b ferr=%b ovr=%b, expected out=%b vld=%b busy=%b ferr=%b ovr=%b",
               name, got[7:4], got[3], got[2], got[1], got[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    clear = 1'b1; in = 1'b1; shift = 1'b0; out_ready = 1'b0;

    // Reset and idle line.
    v(1,1,1,0, 4'h0,0,0,0,0);
    v(1,1,1,0, 4'h0,0,0,0,0);
    for (int i = 0; i < 10; i++) v(0,1,1,0, 4'h0,0,0,0,0);

`ifndef SERIAL_RX_PARITY_EN
    // Frame 1011, held with out_ready=0, then consumed.
    v(0,0,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,0,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'hB,1,0,0,0);
    for (int i = 0; i < 3; i++) v(0,1,1,0, 4'hB,1,0,0,0);
    v(0,1,1,1, 4'hB,0,0,0,0);
    v(0,1,1,1, 4'hB,0,0,0,0);   // ready ignored while not valid
    // Same frame, bad stop bit.
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,0,1,0);
    v(0,1,1,0, 4'hB,0,0,0,0);
    // Good frame 0110.
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'h6,1,0,0,0);
    v(0,1,1,1, 4'h6,0,0,0,0);
    // Back-to-back 1011 then 0001, never consumed -> overrun.
    v(0,0,1,0, 4'h6,0,1,0,0);
    v(0,1,1,0, 4'h6,0,1,0,0);
    v(0,0,1,0, 4'h6,0,1,0,0);
    v(0,1,1,0, 4'h6,0,1,0,0);
    v(0,1,1,0, 4'h6,0,1,0,0);
    v(0,1,1,0, 4'hB,1,0,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,1,1,0, 4'hB,1,1,0,0);
    v(0,1,1,0, 4'hB,1,0,0,1);
    v(0,1,1,0, 4'hB,1,0,0,0);
    v(0,1,1,1, 4'hB,0,0,0,0);
    // Same pair, consumed on the second stop edge -> replaced, no overrun.
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,1,0,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,0,1,0, 4'hB,1,1,0,0);
    v(0,1,1,0, 4'hB,1,1,0,0);
    v(0,1,1,1, 4'h1,1,0,0,0);
    v(0,1,1,0, 4'h1,1,0,0,0);
    v(0,1,1,1, 4'h1,0,0,0,0);
    // Break: all-zero frame, then a held-low line restarts at once.
    v(0,0,1,0, 4'h1,0,1,0,0);
    for (int i = 0; i < 4; i++) v(0,0,1,0, 4'h1,0,1,0,0);
    v(0,0,1,0, 4'h1,0,0,1,0);
    v(0,0,1,0, 4'h1,0,1,0,0);
    v(0,0,1,0, 4'h1,0,1,0,0);
    v(0,1,1,0, 4'h1,0,1,0,0);
    v(0,1,1,0, 4'h1,0,1,0,0);
    v(0,0,1,0, 4'h1,0,1,0,0);
    v(0,1,1,0, 4'h6,1,0,0,0);
    // Bad stop with slot occupied -> frame_err only.
    v(0,0,1,0, 4'h6,1,1,0,0);
    for (int i = 0; i < 4; i++) v(0,1,1,0, 4'h6,1,1,0,0);
    v(0,0,1,0, 4'h6,1,0,1,0);
    v(0,1,1,1, 4'h6,0,0,0,0);
`else
    // Frame 1011 with good parity (1), then with bad parity (0).
    v(0,0,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,0,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'h0,0,1,0,0);
    v(0,1,1,0, 4'hB,1,0,0,0);
    v(0,1,1,1, 4'hB,0,0,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,1,0,0);
    v(0,0,1,0, 4'hB,0,1,0,0);
    v(0,1,1,0, 4'hB,0,0,1,0);
    v(0,1,1,0, 4'hB,0,0,0,0);
`endif

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].din, tbl[i].sh, tbl[i].rdy,
           tbl[i].eout, tbl[i].evld, tbl[i].ebusy, tbl[i].eferr, tbl[i].eovr,
           $sformatf("vec%0d", i));
    end

`ifndef SERIAL_RX_PARITY_EN
    // Stall mid-frame: in=0 during the stall must not be sampled.
    step(0,0,1,0, 4'h6,0,1,0,0, "stall_start");
    step(0,1,1,0, 4'h6,0,1,0,0, "stall_d1");
    step(0,0,1,0, 4'h6,0,1,0,0, "stall_d2");
    for (int i = 0; i < 3; i++) step(0,0,0,0, 4'h6,0,1,0,0, "stall_hold");
    step(0,1,1,0, 4'h6,0,1,0,0, "stall_d3");
    step(0,1,1,0, 4'h6,0,1,0,0, "stall_d4");
    step(0,0,0,0, 4'h6,0,1,0,0, "stall_prestop");
    step(0,1,1,0, 4'hB,1,0,0,0, "stall_word");
    // Clear mid-frame with a held word.
    step(0,0,1,0, 4'hB,1,1,0,0, "clr_start");
    step(0,1,1,0, 4'hB,1,1,0,0, "clr_d1");
    step(1,0,1,0, 4'h0,0,0,0,0, "clr_apply");
    step(0,1,1,0, 4'h0,0,0,0,0, "clr_idle");
    step(0,0,1,0, 4'h0,0,1,0,0, "post_start");
    step(0,0,1,0, 4'h0,0,1,0,0, "post_d1");
    step(0,1,1,0, 4'h0,0,1,0,0, "post_d2");
    step(0,1,1,0, 4'h0,0,1,0,0, "post_d3");
    step(0,0,1,0, 4'h0,0,1,0,0, "post_d4");
    step(0,1,1,0, 4'h6,1,0,0,0, "post_word");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
